kyber_reduction_arbiter: RTL and testbench

Two-requester round-robin arbiter and pipeline sequencer for the shared combinational Kyber modular-reduction unit. It accepts 24-bit products from two clients, such as the NTT butterfly and the pointwise multiplier, over valid/ready handshakes. It drives one operand per cycle into the external reduction unit and returns canonical 12-bit residues tagged with the requester id. Sustained throughput is one reduction per cycle; latency is two cycles.

---
 rtl/kyber_reduction_arbiter.sv | 104 ++++++++++
 tb/tb_kyber_reduction_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_reduction_arbiter.sv
// Round-robin arbiter feeding a shared combinational Kyber reduction unit.
// Two-stage pipeline: S1 drives the unit, S2 holds the canonical residue for the sink.
`timescale 1ns/1ps
module kyber_reduction_arbiter #(
    parameter int DW = 24,
    parameter int MW = 12,
    parameter int Q  = 3329
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req0_valid_i,
    input  logic [DW-1:0] req0_x_i,
    output logic          req0_ready_o,
    input  logic          req1_valid_i,
    input  logic [DW-1:0] req1_x_i,
    output logic          req1_ready_o,
    output logic [DW-1:0] red_x_o,
    output logic [MW-1:0] red_m_o,
    input  logic [DW-1:0] red_res_i,
    output logic          rsp_valid_o,
    output logic [MW-1:0] rsp_data_o,
    output logic          rsp_id_o,
    input  logic          rsp_ready_i,
    output logic          busy_o
);

    logic          s1_v_q, s1_v_d;
    logic [DW-1:0] s1_x_q, s1_x_d;
    logic          s1_id_q, s1_id_d;
    logic          s2_v_q, s2_v_d;
    logic [MW-1:0] s2_data_q, s2_data_d;
    logic          s2_id_q, s2_id_d;
    logic          prio_q, prio_d;

    logic adv1, adv2, gnt_v, gnt_id, accept;

    always_comb begin
        adv2   = !s2_v_q || rsp_ready_i;
        adv1   = !s1_v_q || adv2;
        gnt_v  = req0_valid_i || req1_valid_i;
        gnt_id = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
        // Readies are gated by reset so nothing is accepted while it is held.
        req0_ready_o = rst_ni && adv1 && gnt_v && !gnt_id && req0_valid_i;
        req1_ready_o = rst_ni && adv1 && gnt_v &&  gnt_id && req1_valid_i;
        accept       = req0_ready_o || req1_ready_o;
    end

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_x_d    = s1_x_q;
        s1_id_d   = s1_id_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_id_d   = s2_id_q;
        prio_d    = prio_q;
        if (accept) begin
            s1_v_d  = 1'b1;
            s1_x_d  = gnt_id ? req1_x_i : req0_x_i;
            s1_id_d = gnt_id;
            prio_d  = !gnt_id;
        end else if (adv1) begin
            s1_v_d = 1'b0;
        end
        if (adv2) begin
            if (s1_v_q) begin
                s2_v_d  = 1'b1;
                s2_id_d = s1_id_q;
                // Low-bit subtraction is exact modulo 2^MW, so only the residue bits are needed.
                s2_data_d = (red_res_i >= DW'(Q)) ? (red_res_i[MW-1:0] - MW'(Q))
                                                  : red_res_i[MW-1:0];
            end else begin
                s2_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_v_q    <= 1'b0;
            s1_x_q    <= '0;
            s1_id_q   <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_id_q   <= 1'b0;
            prio_q    <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_x_q    <= s1_x_d;
            s1_id_q   <= s1_id_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_id_q   <= s2_id_d;
            prio_q    <= prio_d;
        end
    end

    assign red_x_o     = s1_x_q;
    assign red_m_o     = MW'(Q);
    assign rsp_valid_o = s2_v_q;
    assign rsp_data_o  = s2_data_q;
    assign rsp_id_o    = s2_id_q;
    assign busy_o      = s1_v_q || s2_v_q;

endmodule

// File: tb/tb_kyber_reduction_arbiter.sv
// Directed bench for kyber_reduction_arbiter with a behavioural x mod Q reduction unit
// that can be overridden by a fixed stub value.
`timescale 1ns/1ps
module tb_kyber_reduction_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0v, r1v, r0r, r1r;
    logic [23:0] r0x, r1x, red_x, red_res;
    logic [11:0] red_m, rsp_d;
    logic        rsp_v, rsp_id, rsp_rdy, busy;
    logic        stub_en;
    logic [23:0] stub_val;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign red_res = stub_en ? stub_val : (red_x % 24'd3329);

    kyber_reduction_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req0_valid_i (r0v),
        .req0_x_i     (r0x),
        .req0_ready_o (r0r),
        .req1_valid_i (r1v),
        .req1_x_i     (r1x),
        .req1_ready_o (r1r),
        .red_x_o      (red_x),
        .red_m_o      (red_m),
        .red_res_i    (red_res),
        .rsp_valid_o  (rsp_v),
        .rsp_data_o   (rsp_d),
        .rsp_id_o     (rsp_id),
        .rsp_ready_i  (rsp_rdy),
        .busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, c1, nr;
        logic s0, s1r;
        c0 = 0; c1 = 0; nr = 0;
        rst_n = 1'b0; r0v = 1'b1; r1v = 1'b0; r0x = 24'd77; r1x = 24'd0;
        rsp_rdy = 1'b1; stub_en = 1'b0; stub_val = 24'd0;

        // Reset state
        #2;
        chk("rst_rsp_v",  32'(rsp_v), 32'd0);
        chk("rst_rsp_d",  32'(rsp_d), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_red_x",  32'(red_x), 32'd0);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_rdy0",   32'(r0r), 32'd0);
        chk("rst_red_m",  32'(red_m), 32'd3329);
        r0v = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        $display("reset released");

        // Contention: (Q-1)^2 reduces to 1, grants alternate starting with req0
        r0x = 24'd11075584; r1x = 24'd11075584; r0v = 1'b1; r1v = 1'b1;
        #1;
        chk("cont_rdy0_first", 32'(r0r), 32'd1);
        chk("cont_rdy1_first", 32'(r1r), 32'd0);
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("cont_rdy0", 32'(r0r), 32'(e % 2 == 0));
            chk("cont_rdy1", 32'(r1r), 32'(e % 2 == 1));
            if (e >= 2) begin
                chk("cont_rsp_v",  32'(rsp_v), 32'd1);
                chk("cont_rsp_id", 32'(rsp_id), 32'((e - 2) % 2));
                chk("cont_rsp_d",  32'(rsp_d), 32'd1);
            end
            $display("contention edge %0d: rsp_v=%0d id=%0d data=%0d", e, rsp_v, rsp_id, rsp_d);
        end
        r0v = 1'b0; r1v = 1'b0;
        tick();
        chk("cont_tail_v",  32'(rsp_v), 32'd1);
        chk("cont_tail_id", 32'(rsp_id), 32'd1);
        tick();
        chk("cont_idle_v",    32'(rsp_v), 32'd0);
        chk("cont_idle_busy", 32'(busy), 32'd0);

        // Single operand 5Q+10 -> 10, response after the second edge only
        r0x = 24'd16655; r0v = 1'b1;
        #1;
        chk("single_rdy0", 32'(r0r), 32'd1);
        tick();
        r0v = 1'b0;
        chk("single_red_x", 32'(red_x), 32'd16655);
        chk("single_early_v", 32'(rsp_v), 32'd0);
        chk("single_busy", 32'(busy), 32'd1);
        tick();
        chk("single_v",  32'(rsp_v), 32'd1);
        chk("single_d",  32'(rsp_d), 32'd10);
        chk("single_id", 32'(rsp_id), 32'd0);
        $display("single: rsp_v=%0d id=%0d data=%0d", rsp_v, rsp_id, rsp_d);
        tick();
        chk("single_after_v", 32'(rsp_v), 32'd0);
        chk("single_after_busy", 32'(busy), 32'd0);

        // Boundaries 0, 3328, 3329 streamed from req1
        r1x = 24'd0; r1v = 1'b1;
        #1;
        chk("bnd_rdy1", 32'(r1r), 32'd1);
        tick();
        r1x = 24'd3328;
        tick();
        chk("bnd_0_v",  32'(rsp_v), 32'd1);
        chk("bnd_0_d",  32'(rsp_d), 32'd0);
        chk("bnd_0_id", 32'(rsp_id), 32'd1);
        r1x = 24'd3329;
        tick();
        chk("bnd_3328_d", 32'(rsp_d), 32'd3328);
        r1v = 1'b0;
        tick();
        chk("bnd_3329_v", 32'(rsp_v), 32'd1);
        chk("bnd_3329_d", 32'(rsp_d), 32'd0);
        $display("boundary: last data=%0d", rsp_d);
        tick();
        chk("bnd_idle_v", 32'(rsp_v), 32'd0);

        // Backpressure: both streaming, sink stalled for cycles 3..7
        r0v = 1'b1; r1v = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            rsp_rdy = !(cyc >= 3 && cyc <= 7);
            r0x = 24'(7 * 3329 + 100 + c0);
            r1x = 24'(7 * 3329 + 200 + c1);
            #1;
            if (cyc >= 3 && cyc <= 7) begin
                chk("bp_rdy0", 32'(r0r), 32'd0);
                chk("bp_rdy1", 32'(r1r), 32'd0);
                chk("bp_busy", 32'(busy), 32'd1);
                chk("bp_hold_v", 32'(rsp_v), 32'd1);
                chk("bp_hold_d", 32'(rsp_d), 32'd200);
                chk("bp_hold_id", 32'(rsp_id), 32'd1);
            end
            s0 = r0r; s1r = r1r;
            if (rsp_v && rsp_rdy) begin
                chk("bp_rsp_id", 32'(rsp_id), 32'(nr % 2));
                chk("bp_rsp_d", 32'(rsp_d), (nr % 2 == 1) ? 32'(200 + nr / 2) : 32'(100 + nr / 2));
                $display("bp response %0d: id=%0d data=%0d", nr, rsp_id, rsp_d);
                nr++;
            end
            tick();
            if (s0) c0++;
            if (s1r) c1++;
        end
        r0v = 1'b0; r1v = 1'b0; rsp_rdy = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            #1;
            if (rsp_v) begin
                chk("bp_drain_id", 32'(rsp_id), 32'(nr % 2));
                chk("bp_drain_d", 32'(rsp_d), (nr % 2 == 1) ? 32'(200 + nr / 2) : 32'(100 + nr / 2));
                $display("bp response %0d: id=%0d data=%0d", nr, rsp_id, rsp_d);
                nr++;
            end
            tick();
        end
        chk("bp_total_rsp", 32'(nr), 32'd11);
        chk("bp_acc0", 32'(c0), 32'd6);
        chk("bp_acc1", 32'(c1), 32'd5);
        chk("bp_idle_busy", 32'(busy), 32'd0);

        // Stubbed reduction result: canonicalisation of Q and Q-1
        stub_en = 1'b1; stub_val = 24'd3329; r0x = 24'd42; r0v = 1'b1;
        tick();
        r0v = 1'b0;
        chk("stub_red_x", 32'(red_x), 32'd42);
        tick();
        chk("stub_q_v", 32'(rsp_v), 32'd1);
        chk("stub_q_d", 32'(rsp_d), 32'd0);
        $display("stub 3329: data=%0d", rsp_d);
        stub_val = 24'd3328; r0v = 1'b1;
        tick();
        r0v = 1'b0;
        tick();
        chk("stub_q1_d", 32'(rsp_d), 32'd3328);
        $display("stub 3328: data=%0d", rsp_d);
        tick();
        stub_en = 1'b0;

        // Reset mid-stream with both stages full
        r0x = 24'd5; r1x = 24'd6; r0v = 1'b1; r1v = 1'b1; rsp_rdy = 1'b0;
        #1;
        chk("mid_rdy1_first", 32'(r1r), 32'd1);
        tick();
        tick();
        chk("mid_full_busy", 32'(busy), 32'd1);
        chk("mid_full_v", 32'(rsp_v), 32'd1);
        chk("mid_full_d", 32'(rsp_d), 32'd6);
        chk("mid_full_rdy0", 32'(r0r), 32'd0);
        chk("mid_full_rdy1", 32'(r1r), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", 32'(rsp_v), 32'd0);
        chk("mid_rst_d", 32'(rsp_d), 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_red_x", 32'(red_x), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rdy0", 32'(r0r), 32'd0);
        chk("mid_rst_rdy1", 32'(r1r), 32'd0);
        $display("mid-stream reset asserted");
        @(posedge clk); @(posedge clk);
        #2;
        rst_n = 1'b1; rsp_rdy = 1'b1;
        #1;
        chk("post_rst_v", 32'(rsp_v), 32'd0);
        chk("post_rst_rdy0", 32'(r0r), 32'd1);
        chk("post_rst_rdy1", 32'(r1r), 32'd0);
        tick();
        r0v = 1'b0; r1v = 1'b0;
        chk("post_rst_red_x", 32'(red_x), 32'd5);
        chk("post_rst_no_rsp", 32'(rsp_v), 32'd0);
        tick();
        chk("post_rst_rsp_v", 32'(rsp_v), 32'd1);
        chk("post_rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("post_rst_rsp_d", 32'(rsp_d), 32'd5);
        $display("post-reset response: id=%0d data=%0d", rsp_id, rsp_d);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
